// File: rtl/interrupt_controller.sv
// Interrupt entry/return sequencer: drains the pipe, pushes return PC and flags,
// fetches the ISR vector, and reverses the sequence on RTI.
module interrupt_controller #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_signal,
  input  logic        rti_dec,
  input  logic        branch_in_flight,
  input  logic        mem_busy,
  input  logic [31:0] pc_current,
  input  logic [2:0]  flags_in,
  input  logic [15:0] mem_rdata,
  output logic        mem_push,
  output logic        mem_pop,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall_fetch,
  output logic        flush_pipe,
  output logic        pc_write,
  output logic [31:0] pc_value,
  output logic        flags_write,
  output logic [2:0]  flags_value,
  output logic        irq_active,
  output logic        busy
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_I_DRAIN  = 4'd1;
  localparam logic [3:0] S_PUSH_HI  = 4'd2;
  localparam logic [3:0] S_PUSH_LO  = 4'd3;
  localparam logic [3:0] S_PUSH_FLG = 4'd4;
  localparam logic [3:0] S_RD_VHI   = 4'd5;
  localparam logic [3:0] S_RD_VLO   = 4'd6;
  localparam logic [3:0] S_LOAD_PC  = 4'd7;
  localparam logic [3:0] S_R_DRAIN  = 4'd8;
  localparam logic [3:0] S_POP_FLG  = 4'd9;
  localparam logic [3:0] S_POP_LO   = 4'd10;
  localparam logic [3:0] S_POP_HI   = 4'd11;
  localparam logic [3:0] S_R_LOAD   = 4'd12;

  // Tags naming which capture register the read data of an issued request belongs to.
  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_VHI  = 3'd1;
  localparam logic [2:0] K_VLO  = 3'd2;
  localparam logic [2:0] K_FLG  = 3'd3;
  localparam logic [2:0] K_LO   = 3'd4;
  localparam logic [2:0] K_HI   = 3'd5;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_prev_q, int_prev_d;
  logic             irq_pending_q, irq_pending_d;
  logic [31:0]      ret_pc_q, ret_pc_d;
  logic [2:0]       snap_flags_q, snap_flags_d;
  logic [15:0]      vhi_q, vhi_d, vlo_q, vlo_d, lo_q, lo_d, hi_q, hi_d;
  logic             rd_done_q, rd_done_d;
  logic [2:0]       req_kind_q, req_kind_d, cap_kind_q, cap_kind_d;
  logic             mem_push_q, mem_push_d, mem_pop_q, mem_pop_d, mem_read_q, mem_read_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic             stall_q, stall_d, flush_q, flush_d, pc_write_q, pc_write_d;
  logic [31:0]      pc_value_q, pc_value_d;
  logic             flags_write_q, flags_write_d;
  logic [2:0]       flags_value_q, flags_value_d;
  logic             irq_active_q, irq_active_d, busy_q, busy_d;
  logic             take_c;

  // Next-state, capture and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    int_prev_d    = interrupt_signal;
    ret_pc_d      = ret_pc_q;
    snap_flags_d  = snap_flags_q;
    vhi_d         = vhi_q;
    vlo_d         = vlo_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    rd_done_d     = rd_done_q;
    req_kind_d    = K_NONE;
    cap_kind_d    = req_kind_q;
    mem_push_d    = 1'b0;
    mem_pop_d     = 1'b0;
    mem_read_d    = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    flush_d       = 1'b0;
    pc_write_d    = 1'b0;
    pc_value_d    = '0;
    flags_write_d = 1'b0;
    flags_value_d = '0;
    irq_active_d  = irq_active_q;
    take_c        = 1'b0;

    // Read data arrives the cycle after the request was visible on the bus.
    case (cap_kind_q)
      K_VHI: vhi_d = mem_rdata;
      K_VLO: begin vlo_d = mem_rdata; rd_done_d = 1'b1; end
      K_FLG: begin flags_write_d = 1'b1; flags_value_d = mem_rdata[2:0]; end
      K_LO:  lo_d = mem_rdata;
      K_HI:  begin hi_d = mem_rdata; rd_done_d = 1'b1; end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        rd_done_d = 1'b0;
        if (irq_pending_q && !irq_active_q && !branch_in_flight) begin
          take_c       = 1'b1;
          state_d      = S_I_DRAIN;
          cnt_d        = CNT_INIT;
          ret_pc_d     = pc_current;
          snap_flags_d = flags_in;
        end else if (rti_dec && irq_active_q) begin
          state_d = S_R_DRAIN;
          cnt_d   = CNT_INIT;
        end
      end
      S_I_DRAIN, S_R_DRAIN: begin
        if (cnt_q == '0) state_d = (state_q == S_I_DRAIN) ? S_PUSH_HI : S_POP_FLG;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_PUSH_HI: if (!mem_busy) begin
        mem_push_d  = 1'b1;
        mem_wdata_d = ret_pc_q[31:16];
        state_d     = S_PUSH_LO;
      end
      S_PUSH_LO: if (!mem_busy) begin
        mem_push_d  = 1'b1;
        mem_wdata_d = ret_pc_q[15:0];
        state_d     = S_PUSH_FLG;
      end
      S_PUSH_FLG: if (!mem_busy) begin
        mem_push_d  = 1'b1;
        mem_wdata_d = {13'b0, snap_flags_q};
        state_d     = S_RD_VHI;
      end
      S_RD_VHI: if (!mem_busy) begin
        mem_read_d = 1'b1;
        mem_addr_d = VECTOR_ADDR;
        req_kind_d = K_VHI;
        state_d    = S_RD_VLO;
      end
      S_RD_VLO: if (!mem_busy) begin
        mem_read_d = 1'b1;
        mem_addr_d = VECTOR_ADDR + 32'd1;
        req_kind_d = K_VLO;
        state_d    = S_LOAD_PC;
      end
      S_LOAD_PC: if (rd_done_q) begin
        pc_write_d   = 1'b1;
        pc_value_d   = {vhi_q, vlo_q};
        flush_d      = 1'b1;
        irq_active_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_POP_FLG: if (!mem_busy) begin
        mem_pop_d  = 1'b1;
        req_kind_d = K_FLG;
        state_d    = S_POP_LO;
      end
      S_POP_LO: if (!mem_busy) begin
        mem_pop_d  = 1'b1;
        req_kind_d = K_LO;
        state_d    = S_POP_HI;
      end
      S_POP_HI: if (!mem_busy) begin
        mem_pop_d  = 1'b1;
        req_kind_d = K_HI;
        state_d    = S_R_LOAD;
      end
      S_R_LOAD: if (rd_done_q) begin
        pc_write_d   = 1'b1;
        pc_value_d   = {hi_q, lo_q};
        flush_d      = 1'b1;
        irq_active_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new edge wins over the clear caused by taking the previous one.
    irq_pending_d = (interrupt_signal & ~int_prev_q) | (irq_pending_q & ~take_c);
    stall_d       = (state_d != S_IDLE);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      int_prev_q    <= 1'b0;
      irq_pending_q <= 1'b0;
      ret_pc_q      <= '0;
      snap_flags_q  <= '0;
      vhi_q         <= '0;
      vlo_q         <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
      rd_done_q     <= 1'b0;
      req_kind_q    <= K_NONE;
      cap_kind_q    <= K_NONE;
      mem_push_q    <= 1'b0;
      mem_pop_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      pc_write_q    <= 1'b0;
      pc_value_q    <= '0;
      flags_write_q <= 1'b0;
      flags_value_q <= '0;
      irq_active_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      int_prev_q    <= int_prev_d;
      irq_pending_q <= irq_pending_d;
      ret_pc_q      <= ret_pc_d;
      snap_flags_q  <= snap_flags_d;
      vhi_q         <= vhi_d;
      vlo_q         <= vlo_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      rd_done_q     <= rd_done_d;
      req_kind_q    <= req_kind_d;
      cap_kind_q    <= cap_kind_d;
      mem_push_q    <= mem_push_d;
      mem_pop_q     <= mem_pop_d;
      mem_read_q    <= mem_read_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      pc_write_q    <= pc_write_d;
      pc_value_q    <= pc_value_d;
      flags_write_q <= flags_write_d;
      flags_value_q <= flags_value_d;
      irq_active_q  <= irq_active_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_push    = mem_push_q;
  assign mem_pop     = mem_pop_q;
  assign mem_read    = mem_read_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign stall_fetch = stall_q;
  assign flush_pipe  = flush_q;
  assign pc_write    = pc_write_q;
  assign pc_value    = pc_value_q;
  assign flags_write = flags_write_q;
  assign flags_value = flags_value_q;
  assign irq_active  = irq_active_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a small stack/vector memory model.
`timescale 1ns/1ps
module tb_interrupt_controller;

  localparam logic [31:0] VEC   = 32'h0000_0000;
  localparam int          DRAIN = 3;

  logic        clk = 1'b0, rst = 1'b0;
  logic        interrupt_signal = 1'b0, rti_dec = 1'b0;
  logic        branch_in_flight = 1'b0, mem_busy = 1'b0;
  logic [31:0] pc_current = '0;
  logic [2:0]  flags_in = '0;
  logic [15:0] mem_rdata = '0;
  logic        mem_push, mem_pop, mem_read, stall_fetch, flush_pipe, pc_write;
  logic        flags_write, irq_active, busy;
  logic [31:0] mem_addr, pc_value;
  logic [15:0] mem_wdata;
  logic [2:0]  flags_value;
  logic [91:0] all_outs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] stack_mem[$];
  logic [15:0] push_log[$];
  logic [31:0] read_log[$];
  int          pop_cnt = 0;
  logic [15:0] vec_hi = '0, vec_lo = '0, rdata_pipe = 16'hDEAD;

  interrupt_controller #(.VECTOR_ADDR(VEC), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .interrupt_signal(interrupt_signal), .rti_dec(rti_dec),
    .branch_in_flight(branch_in_flight), .mem_busy(mem_busy), .pc_current(pc_current),
    .flags_in(flags_in), .mem_rdata(mem_rdata), .mem_push(mem_push), .mem_pop(mem_pop),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall_fetch(stall_fetch), .flush_pipe(flush_pipe), .pc_write(pc_write),
    .pc_value(pc_value), .flags_write(flags_write), .flags_value(flags_value),
    .irq_active(irq_active), .busy(busy)
  );

  assign all_outs = {mem_push, mem_pop, mem_read, mem_addr, mem_wdata, stall_fetch,
                     flush_pipe, pc_write, pc_value, flags_write, flags_value, irq_active, busy};

  always #5 clk = ~clk;

  // Memory model: data for a request seen in one cycle is driven for the following cycle.
  always @(negedge clk) begin
    mem_rdata  = rdata_pipe;
    rdata_pipe = 16'hDEAD;
    if (mem_push) begin
      stack_mem.push_back(mem_wdata);
      push_log.push_back(mem_wdata);
    end
    if (mem_pop) begin
      pop_cnt++;
      if (stack_mem.size() > 0) rdata_pipe = stack_mem.pop_back();
    end
    if (mem_read) begin
      read_log.push_back(mem_addr);
      if (mem_addr == VEC)              rdata_pipe = vec_hi;
      else if (mem_addr == VEC + 32'd1) rdata_pipe = vec_lo;
    end
  end

  task automatic pulse_irq();
    @(negedge clk) interrupt_signal = 1'b1;
    repeat (2) @(negedge clk);
    interrupt_signal = 1'b0;
  endtask

  task automatic pulse_rti();
    @(negedge clk) rti_dec = 1'b1;
    @(negedge clk) rti_dec = 1'b0;
  endtask

  task automatic wait_pc_write(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (pc_write) begin cyc = i; break; end
    end
  endtask

  task automatic wait_flags_write(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (flags_write) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    n_checks++;
    if (busy !== 1'b0 || irq_active !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_active: got %b%b expected 00", busy, irq_active);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_entry();
    int cyc;
    logic [47:0] got48;
    logic [63:0] got_rd;
    vec_hi = 16'h0000; vec_lo = 16'h0100;
    pc_current = 32'h0000_0040; flags_in = 3'b101;
    push_log.delete(); read_log.delete();
    @(negedge clk) interrupt_signal = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) interrupt_signal = 1'b0;
      if (i == 3) begin pc_current = 32'h0000_0044; flags_in = 3'b000; end
      if (mem_push) begin cyc = i; break; end
    end
    // Rise sampled on the first edge, first push visible 2+DRAIN edges later.
    n_checks++;
    if (cyc != DRAIN + 3) begin
      n_fail++; $display("FAIL entry_latency: got %0d expected %0d", cyc, DRAIN + 3);
    end
    n_checks++;
    if (stall_fetch !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL entry_stall_busy: got %b%b expected 11", stall_fetch, busy);
    end
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0000_0100 || flush_pipe !== 1'b1) begin
      n_fail++; $display("FAIL entry_pc_write: got pc %h flush %b wait %0d expected 00000100 1", pc_value, flush_pipe, cyc);
    end
    @(negedge clk);
    n_checks++;
    if (irq_active !== 1'b1 || busy !== 1'b0 || stall_fetch !== 1'b0) begin
      n_fail++; $display("FAIL entry_active: got act %b busy %b stall %b expected 1 0 0", irq_active, busy, stall_fetch);
    end
    got48 = '1;
    if (push_log.size() == 3) got48 = {push_log[0], push_log[1], push_log[2]};
    n_checks++;
    if (got48 !== 48'h0000_0040_0005) begin
      n_fail++; $display("FAIL entry_pushes: got %h expected 000000400005", got48);
    end
    got_rd = '1;
    if (read_log.size() == 2) got_rd = {read_log[0], read_log[1]};
    n_checks++;
    if (got_rd !== {VEC, VEC + 32'd1}) begin
      n_fail++; $display("FAIL entry_vector_reads: got %h expected %h", got_rd, {VEC, VEC + 32'd1});
    end
  endtask

  task automatic test_rti();
    int cyc;
    pc_current = 32'h0000_0100; flags_in = 3'b000;
    pop_cnt = 0;
    pulse_rti();
    wait_flags_write(cyc);
    n_checks++;
    if (cyc < 0 || flags_value !== 3'b101) begin
      n_fail++; $display("FAIL rti_flags: got %b wait %0d expected 101", flags_value, cyc);
    end
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0000_0040 || flush_pipe !== 1'b1) begin
      n_fail++; $display("FAIL rti_pc_write: got pc %h flush %b expected 00000040 1", pc_value, flush_pipe);
    end
    @(negedge clk);
    n_checks++;
    if (irq_active !== 1'b0 || busy !== 1'b0 || pop_cnt != 3 || stack_mem.size() != 0) begin
      n_fail++; $display("FAIL rti_done: got act %b busy %b pops %0d depth %0d expected 0 0 3 0", irq_active, busy, pop_cnt, stack_mem.size());
    end
  endtask

  task automatic test_back_to_back_busy();
    int cyc, gap;
    logic [47:0] got48;
    vec_hi = 16'h0001; vec_lo = 16'h0200;
    pc_current = 32'h1234_5678; flags_in = 3'b010;
    push_log.delete();
    pulse_irq();
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_push) begin cyc = i; break; end
    end
    mem_busy = 1'b1;
    gap = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (mem_push || mem_pop || mem_read) break;
      gap++;
      if (gap == 4) mem_busy = 1'b0;
    end
    mem_busy = 1'b0;
    n_checks++;
    if (cyc < 0 || gap != 4 || mem_push !== 1'b1 || mem_wdata !== 16'h5678) begin
      n_fail++; $display("FAIL busy_gap: got gap %0d push %b data %h expected 4 1 5678", gap, mem_push, mem_wdata);
    end
    @(negedge clk);
    n_checks++;
    if (mem_push !== 1'b1 || mem_wdata !== 16'h0002) begin
      n_fail++; $display("FAIL busy_flag_push: got push %b data %h expected 1 0002", mem_push, mem_wdata);
    end
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0001_0200) begin
      n_fail++; $display("FAIL busy_vector_pc: got %h expected 00010200", pc_value);
    end
    got48 = '1;
    if (push_log.size() == 3) got48 = {push_log[0], push_log[1], push_log[2]};
    n_checks++;
    if (got48 !== 48'h1234_5678_0002) begin
      n_fail++; $display("FAIL busy_pushes: got %h expected 123456780002", got48);
    end
    pulse_rti();
    wait_flags_write(cyc);
    n_checks++;
    if (cyc < 0 || flags_value !== 3'b010) begin
      n_fail++; $display("FAIL busy_rti_flags: got %b expected 010", flags_value);
    end
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h1234_5678) begin
      n_fail++; $display("FAIL busy_rti_pc: got %h expected 12345678", pc_value);
    end
  endtask

  task automatic test_nested();
    int cyc, nb;
    vec_hi = 16'h0000; vec_lo = 16'h0100;
    pc_current = 32'h0000_0200; flags_in = 3'b001;
    pulse_irq();
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0000_0100) begin
      n_fail++; $display("FAIL nest_first_entry: got %h expected 00000100", pc_value);
    end
    pulse_irq();
    nb = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy || mem_push) nb++;
    end
    n_checks++;
    if (nb != 0) begin
      n_fail++; $display("FAIL nest_no_entry: got %0d busy cycles expected 0", nb);
    end
    pulse_rti();
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0000_0200 || irq_active !== 1'b0) begin
      n_fail++; $display("FAIL nest_rti: got pc %h act %b expected 00000200 0", pc_value, irq_active);
    end
    push_log.delete();
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0000_0100 || push_log.size() != 3) begin
      n_fail++; $display("FAIL nest_reentry: got pc %h pushes %0d expected 00000100 3", pc_value, push_log.size());
    end
    pulse_rti();
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0000_0200) begin
      n_fail++; $display("FAIL nest_final_rti: got %h expected 00000200", pc_value);
    end
  endtask

  task automatic test_branch_and_stray_rti();
    int cyc, nb, pops0;
    @(negedge clk);
    pops0 = pop_cnt;
    pulse_rti();
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || mem_pop) nb++;
    end
    n_checks++;
    if (nb != 0 || pop_cnt != pops0) begin
      n_fail++; $display("FAIL stray_rti: got %0d busy cycles %0d pops expected 0 0", nb, pop_cnt - pops0);
    end
    branch_in_flight = 1'b1;
    pc_current = 32'h0000_0300; flags_in = 3'b110;
    pulse_irq();
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    n_checks++;
    if (nb != 0) begin
      n_fail++; $display("FAIL branch_defer: got %0d busy cycles expected 0", nb);
    end
    branch_in_flight = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy) begin cyc = i; break; end
    end
    n_checks++;
    if (cyc != 1) begin
      n_fail++; $display("FAIL branch_release: got %0d expected 1", cyc);
    end
    wait_pc_write(cyc);
    pulse_rti();
    wait_flags_write(cyc);
    n_checks++;
    if (cyc < 0 || flags_value !== 3'b110) begin
      n_fail++; $display("FAIL branch_rti_flags: got %b expected 110", flags_value);
    end
    wait_pc_write(cyc);
    n_checks++;
    if (cyc < 0 || pc_value !== 32'h0000_0300) begin
      n_fail++; $display("FAIL branch_rti_pc: got %h expected 00000300", pc_value);
    end
  endtask

  task automatic test_reset_mid();
    int np, nr;
    pc_current = 32'h0000_0500; flags_in = 3'b011;
    pulse_irq();
    np = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_push) np++;
      if (np == 2) break;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (np != 2 || all_outs !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h pushes %0d expected 0 2", all_outs, np);
    end
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_push || mem_pop || mem_read) nr++;
    end
    stack_mem.delete();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy || mem_push || mem_pop || mem_read) nr++;
    end
    n_checks++;
    if (nr != 0 || irq_active !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_abandon: got %0d active cycles act %b expected 0 0", nr, irq_active);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_entry();
    test_rti();
    test_back_to_back_busy();
    test_nested();
    test_branch_and_stray_rti();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
